multicycle_ctrl: RTL

Multi-cycle sequencer for the RV32I datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and turns the level-type control from main_decoder (RegWEn, MemRW, MemToReg, Branch, Jump) into per-cycle write enables and memory requests. It also handles memory ready handshakes, debug halt, illegal-opcode and memory-timeout traps, and a retired-instruction counter.

---
 rtl/multicycle_ctrl_pkg.sv | 55 +++++
 rtl/multicycle_ctrl_mem_wait_timer.sv | 37 +++
 rtl/multicycle_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: FSM states, trap causes,
// the legal opcode set and the per-cycle strobe bundle.
package multicycle_ctrl_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned CAUSE_W  = 2;
  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OPCODE_R       = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPCODE_I_ARITH = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPCODE_LOAD    = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPCODE_S       = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPCODE_B       = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPCODE_LUI     = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPCODE_AUIPC   = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPCODE_JAL     = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPCODE_JALR    = 7'b1100111;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_ILLEGAL  = 2'b01,
    CAUSE_IMEM_TMO = 2'b10,
    CAUSE_DMEM_TMO = 2'b11
  } trap_cause_e;

  typedef struct packed {
    logic imem_req;
    logic dmem_req;
    logic dmem_we;
    logic ir_we;
    logic pc_we;
    logic pc_sel;
    logic reg_we;
  } strobe_t;

  // Opcodes the datapath can execute; anything else traps in DECODE.
  function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] op);
    case (op)
      OPCODE_R, OPCODE_I_ARITH, OPCODE_LOAD, OPCODE_S, OPCODE_B,
      OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Wait-cycle counter shared by instruction fetch and data access; flags the
// cycle in which a still-unanswered request has used up its timeout budget.
module multicycle_ctrl_mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic ready_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting_c;

  assign waiting_c = req_i & ~ready_i;
  assign expired_o = waiting_c & (cnt_q == CW'(TIMEOUT - 1));

  // Count only unanswered request cycles; ready, idle or expiry restarts at zero.
  always_comb begin
    cnt_d = '0;
    if (waiting_c && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps FETCH/DECODE/EXEC/MEM/WB, converts level
// decoder control into per-cycle strobes, handles halt, traps and retire count.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                dec_reg_wen,
  input  logic                dec_mem_rw,
  input  logic                dec_mem_to_reg,
  input  logic                dec_branch,
  input  logic                dec_jump,
  input  logic                branch_taken,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                halt_req,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_we,
  output logic                pc_we,
  output logic                pc_sel,
  output logic                reg_we,
  output logic                halted,
  output logic                trap,
  output logic [CAUSE_W-1:0]  trap_cause,
  output logic [CNT_W-1:0]    retired,
  output logic [STATE_W-1:0]  state
);

  state_e           state_q, state_d;
  trap_cause_e      cause_q, cause_d;
  logic [CNT_W-1:0] retired_q;
  strobe_t          strb;
  logic             retire_c;
  logic             wait_req_c;
  logic             wait_ready_c;
  logic             expired_c;
  state_e           next_fetch_c;

  assign wait_req_c   = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign wait_ready_c = (state_q == ST_FETCH) ? imem_ready : dmem_ready;

  multicycle_ctrl_mem_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (wait_req_c),
    .ready_i   (wait_ready_c),
    .expired_o (expired_c)
  );

  // A pending halt diverts any instruction boundary into HALT.
  assign next_fetch_c = halt_req ? ST_HALT : ST_FETCH;

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    strb     = '0;
    retire_c = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        strb.imem_req = 1'b1;
        if (imem_ready) begin
          strb.ir_we = 1'b1;
          state_d    = ST_DECODE;
        end else if (expired_c) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IMEM_TMO;
        end
      end
      ST_DECODE: begin
        if (is_legal_opcode(opcode)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (dec_branch) begin
          strb.pc_we  = 1'b1;
          strb.pc_sel = branch_taken;
          retire_c    = 1'b1;
          state_d     = next_fetch_c;
        end else if (dec_mem_to_reg || dec_mem_rw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        strb.dmem_req = 1'b1;
        strb.dmem_we  = dec_mem_rw;
        if (dmem_ready) begin
          if (dec_mem_rw) begin
            strb.pc_we = 1'b1;
            retire_c   = 1'b1;
            state_d    = next_fetch_c;
          end else begin
            state_d = ST_WB;
          end
        end else if (expired_c) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DMEM_TMO;
        end
      end
      ST_WB: begin
        strb.reg_we = dec_reg_wen;
        strb.pc_we  = 1'b1;
        strb.pc_sel = dec_jump;
        retire_c    = 1'b1;
        state_d     = next_fetch_c;
      end
      ST_HALT: begin
        if (!halt_req) begin
          state_d = ST_FETCH;
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (retire_c) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // Strobes are forced low while reset is asserted so in-flight requests drop at once.
  assign imem_req   = rst_n & strb.imem_req;
  assign dmem_req   = rst_n & strb.dmem_req;
  assign dmem_we    = rst_n & strb.dmem_we;
  assign ir_we      = rst_n & strb.ir_we;
  assign pc_we      = rst_n & strb.pc_we;
  assign pc_sel     = rst_n & strb.pc_sel;
  assign reg_we     = rst_n & strb.reg_we;
  assign halted     = (state_q == ST_HALT);
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = cause_q;
  assign retired    = retired_q;
  assign state      = state_q;

endmodule
